// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Digit width, the largest legal BCD code, run-control states and nibble sanitising.
package bcd_countdown_timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Non-BCD codes (A..F) are clamped to 9 so count never holds an illegal digit.
  function automatic logic [BCD_W-1:0] sanitizeNibble(input logic [BCD_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control and status bundle between the timebase/control logic and the countdown timer.
// The master drives the requests; the slave (the timer) returns count and status.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);

  logic                  i_tick;
  logic                  i_start;
  logic                  i_stop;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_loadVal;
  logic                  i_autoReload;
  logic [4*DIGITS-1:0]   o_count;
  logic                  o_zero;
  logic                  o_done;
  logic                  o_running;

  modport master (
    output i_tick, i_start, i_stop, i_load, i_loadVal, i_autoReload,
    input  o_count, o_zero, o_done, o_running
  );

  modport slave (
    input  i_tick, i_start, i_stop, i_load, i_loadVal, i_autoReload,
    output o_count, o_zero, o_done, o_running
  );

endinterface

// File: rtl/bcd_countdown_timer_digit_dec.sv
// Single BCD digit combinational decrement with borrow in/out.
// A digit at 0 wraps to 9 and passes the borrow on to the next digit.
module bcd_digit_dec
  import bcd_countdown_timer_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  input  logic             i_borrow,
  output logic [BCD_W-1:0] o_nextDigit,
  output logic             o_borrow
);

  logic w_isZero;

  assign w_isZero    = (i_digit == '0);
  assign o_borrow    = i_borrow & w_isZero;
  assign o_nextDigit = !i_borrow ? i_digit :
                       (w_isZero ? BCD_MAX : i_digit - 4'd1);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with load/reload, one-shot or auto-reload, and start/stop control.
// Holds the count and reload registers, the run-control FSM and the terminal-count pulse.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int                  DIGITS    = 2,
  parameter logic [4*DIGITS-1:0] RESET_VAL = 8'h59
) (
  input logic                    clk,
  input logic                    rst,
  bcd_countdown_timer_if.slave   bus
);

  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] r_reload;
  logic                r_done;
  state_t              r_state;

  logic [4*DIGITS-1:0] w_dec;
  logic [4*DIGITS-1:0] w_loadSan;
  logic [DIGITS:0]     w_borrow;
  logic                w_zero;

  // Borrow ripples up from digit 0; it escapes the top digit only when every digit is 0.
  assign w_borrow[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_dec u_dec (
      .i_digit     (r_count[g*BCD_W +: BCD_W]),
      .i_borrow    (w_borrow[g]),
      .o_nextDigit (w_dec[g*BCD_W +: BCD_W]),
      .o_borrow    (w_borrow[g+1])
    );
  end

  assign w_zero = w_borrow[DIGITS];

  always_comb begin
    w_loadSan = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_loadSan[i*BCD_W +: BCD_W] = sanitizeNibble(bus.i_loadVal[i*BCD_W +: BCD_W]);
    end
  end

  // Priority each cycle: load, then stop, then start, then tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= RESET_VAL;
      r_reload <= RESET_VAL;
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.i_load) begin
        r_count  <= w_loadSan;
        r_reload <= w_loadSan;
        r_state  <= ST_IDLE;
      end else if (bus.i_stop && r_state == ST_RUN) begin
        r_state <= ST_IDLE;
      end else if (bus.i_start && r_state != ST_RUN) begin
        if (!w_zero || bus.i_autoReload) begin
          r_state <= ST_RUN;
        end
      end else if (bus.i_tick && r_state == ST_RUN) begin
        if (!w_zero) begin
          r_count <= w_dec;
          if (w_dec == '0) begin
            r_done <= 1'b1;
            if (!bus.i_autoReload) begin
              r_state <= ST_DONE;
            end
          end
        end else if (bus.i_autoReload) begin
          r_count <= r_reload;
        end else begin
          r_state <= ST_DONE;
        end
      end
    end
  end

  assign bus.o_count   = r_count;
  assign bus.o_zero    = w_zero;
  assign bus.o_done    = r_done;
  assign bus.o_running = (r_state == ST_RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed testbench for bcd_countdown_timer: a 2-digit instance for the main scenarios
// and a 3-digit instance for the long borrow ripple.
module tb_bcd_countdown_timer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bcd_countdown_timer_if #(.DIGITS(2)) busA ();
  bcd_countdown_timer_if #(.DIGITS(3)) busB ();

  bcd_countdown_timer #(.DIGITS(2), .RESET_VAL(8'h59)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA.slave)
  );

  bcd_countdown_timer #(.DIGITS(3), .RESET_VAL(12'h059)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle of requests on the 2-digit instance, then clears the strobes.
  task automatic applyStimulus(input logic t, input logic s, input logic p, input logic l,
                               input logic [7:0] v, input logic ar);
    busA.i_tick       = t;
    busA.i_start      = s;
    busA.i_stop       = p;
    busA.i_load       = l;
    busA.i_loadVal    = v;
    busA.i_autoReload = ar;
    @(posedge clk);
    #1;
    busA.i_tick  = 1'b0;
    busA.i_start = 1'b0;
    busA.i_stop  = 1'b0;
    busA.i_load  = 1'b0;
  endtask

  task automatic checkA(input string tag, input logic [7:0] cnt, input logic z,
                        input logic d, input logic r);
    checkOutput({tag, ".count"},   32'(busA.o_count),   32'(cnt));
    checkOutput({tag, ".zero"},    32'(busA.o_zero),    32'(z));
    checkOutput({tag, ".done"},    32'(busA.o_done),    32'(d));
    checkOutput({tag, ".running"}, 32'(busA.o_running), 32'(r));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    busA.i_tick = 0; busA.i_start = 0; busA.i_stop = 0; busA.i_load = 0;
    busA.i_loadVal = '0; busA.i_autoReload = 0;
    busB.i_tick = 0; busB.i_start = 0; busB.i_stop = 0; busB.i_load = 0;
    busB.i_loadVal = '0; busB.i_autoReload = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkA("reset", 8'h59, 0, 0, 0);

    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("idleTicks", 8'h59, 0, 0, 0);

    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("run58", 8'h58, 0, 0, 1);
    rst = 1'b1;
    #1;
    checkA("asyncReset", 8'h59, 0, 0, 0);
    #2;
    rst = 1'b0;

    applyStimulus(0, 0, 0, 1, 8'h10, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    checkA("start10", 8'h10, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("borrow09", 8'h09, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 8'h00, 0);
    checkA("load00", 8'h00, 1, 0, 0);

    applyStimulus(0, 0, 0, 1, 8'h03, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("oneShot02", 8'h02, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("oneShot01", 8'h01, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("oneShot00", 8'h00, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 8'h00, 0);
    checkA("doneHold", 8'h00, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    checkA("startIgnored", 8'h00, 1, 0, 0);

    applyStimulus(0, 0, 0, 1, 8'h02, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("auto01", 8'h01, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("auto00", 8'h00, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("autoReload", 8'h02, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("auto01b", 8'h01, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("auto00b", 8'h00, 1, 1, 1);

    applyStimulus(0, 0, 0, 1, 8'h45, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    applyStimulus(1, 0, 1, 0, 8'h00, 1);
    checkA("tickStop", 8'h45, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 8'h00, 1);
    checkA("startTick", 8'h45, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("tick44", 8'h44, 0, 0, 1);
    applyStimulus(1, 1, 0, 1, 8'h30, 1);
    checkA("loadWins", 8'h30, 0, 0, 0);

    applyStimulus(0, 0, 0, 1, 8'hAF, 0);
    checkA("sanitize", 8'h99, 0, 0, 0);

    applyStimulus(0, 0, 0, 1, 8'h00, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    checkA("zeroReloadStart", 8'h00, 1, 0, 1);
    applyStimulus(1, 0, 0, 0, 8'h00, 1);
    checkA("zeroReloadTick", 8'h00, 1, 0, 1);

    busB.i_loadVal = 12'h100;
    busB.i_load    = 1'b1;
    @(posedge clk); #1;
    busB.i_load  = 1'b0;
    busB.i_start = 1'b1;
    @(posedge clk); #1;
    busB.i_start = 1'b0;
    busB.i_tick  = 1'b1;
    @(posedge clk); #1;
    busB.i_tick  = 1'b0;
    checkOutput("d3.count",   32'(busB.o_count),   32'h099);
    checkOutput("d3.done",    32'(busB.o_done),    32'd0);
    checkOutput("d3.running", 32'(busB.o_running), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD down-counter with a small run-control state machine.
- Generalises the single-digit 5→0 / 9→0 down counter:
  - N digits with borrow chaining.
  - Loadable start value, held as the reload value.
  - Auto-reload or one-shot mode.
  - Start/stop control, tick qualification and a terminal-count pulse.
- Sits between the timebase tick generator and the 7-segment display/decoder logic.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- RESET_VAL, 8'h59, count and reload value after reset; width 4*DIGITS; each nibble must be ≤ 9.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle count qualifier from the timebase; decrement only on tick.
- start  in  1  synchronous start/resume request.
- stop  in  1  synchronous pause request.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value captured on load.
- auto_reload  in  1  1 = reload on a tick at zero; 0 = one-shot, stop at zero.
- count  out  4*DIGITS  current BCD count (registered).
- zero  out  1  count == 0; combinational decode of the count register.
- done  out  1  one-cycle registered pulse when count reaches 0.
- running  out  1  state == RUN.

Behaviour:
- Reset (async, rst=1):
  - count = RESET_VAL, reload register = RESET_VAL.
  - state = IDLE, done = 0, running = 0.
  - zero reflects RESET_VAL.
- States:
  - IDLE: count held.
  - RUN: count decrements on tick.
  - DONE: one-shot finished, count held at 0.
- Per-cycle priority: load > stop > start > tick.
- load (any state):
  - count ← sanitised load_val; reload ← sanitised load_val.
  - state → IDLE; done = 0 that cycle.
  - Sanitising: any nibble > 9 is clamped to 9.
- stop in RUN: → IDLE, no decrement that cycle, even if tick=1. stop in IDLE or DONE: no effect.
- start in IDLE or DONE:
  - If count ≠ 0: → RUN.
  - If count = 0 and auto_reload = 1: → RUN.
  - If count = 0 and auto_reload = 0: ignored, state unchanged.
  - No decrement in the start cycle, even if tick=1.
  - start in RUN: no effect.
- tick in RUN with count ≠ 0:
  - Subtract 1 in BCD. Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit. Borrow ripples within the same cycle.
  - Result is registered next edge (latency 1 cycle).
- Reaching zero: when a decrement produces count = 0, done = 1 in the same cycle count shows 0.
  - auto_reload = 0: state → DONE.
  - auto_reload = 1: stay in RUN.
- tick in RUN with count = 0 (auto_reload = 1 path, or a 0 loaded while running was not possible because load forces IDLE):
  - auto_reload = 1: count ← reload, no done.
  - auto_reload = 0: → DONE, count held.
- auto_reload is sampled at every tick/start; changing it mid-run takes effect at the next tick.
- tick outside RUN: ignored.
- done is high for exactly one cycle per zero arrival; it is never asserted on reload, load or reset.
- Reload value 0 with auto_reload = 1: count stays 0; no done on subsequent ticks.
- Reset mid-run: immediate async return to RESET_VAL/IDLE; the reload register also returns to RESET_VAL.
- Only BCD codes 0-9 ever appear on any nibble of count.

Decomposition:
- Shared package (timer_pkg):
  - BCD digit width constant (4).
  - BCD_MAX (4'd9).
  - state encoding typedef (IDLE, RUN, DONE).
  - function sanitising a nibble (clamp > 9 to 9).
- One sub-module: bcd_digit_dec, a single-digit combinational decrement.
  - Inputs: digit, borrow_in.
  - Outputs: next_digit, borrow_out (borrow_out = borrow_in & digit == 0).
  - Instantiated DIGITS times in a generate chain.
- The top level holds the registers, the FSM and done generation.

Test Plan:
- Reset and hold, DIGITS=2: assert rst mid-operation → count = 8'h59, running = 0, zero = 0, done = 0 immediately (asynchronous); ticks in IDLE leave 59.
- Borrow: load 8'h10, start, 1 tick → count 8'h09; load 8'h00 → zero = 1, running = 0.
- One-shot: load 8'h03, auto_reload = 0, start, 3 ticks → 02, 01, 00 with done = 1 exactly at 00, state DONE; further ticks keep 00, done = 0; start ignored.
- Auto-reload: load 8'h02, auto_reload = 1, start, 5 ticks → 01, 00 (done pulse), 02, 01, 00 (done pulse), with no done on the reload.
- Priority and pause: RUN at 8'h45:
  - tick + stop → 45, IDLE.
  - start + tick → 45, RUN.
  - tick → 44.
  - load 8'h30 + start + tick → 30, IDLE.
- Sanitise: load 8'hAF → count 8'h99; DIGITS=3 with load 12'h100, start, tick → 12'h099.
